// File: rtl/bp_fe_ras_pkg.sv
// Shared widths and checkpoint layout for the front-end return-address stack.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// The checkpoint struct depends on the stack's parameters. SystemVerilog
// packages cannot take parameters, so the struct is declared through a macro
// that each user expands with its own vaddr/depth values.
// The struct is ordered {tos_ptr, count, top_addr}, with top_addr in the LSBs.
package bp_fe_ras_pkg;

  localparam int unsigned bp_fe_ras_vaddr_width_gp = 39;
  localparam int unsigned bp_fe_ras_depth_gp       = 8;

  // Index width for a stack of the given depth (depth is a power of two, >= 2).
  function automatic int unsigned bp_fe_ras_ptr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Occupancy needs one more bit than the index so that "full" (== depth) fits.
  function automatic int unsigned bp_fe_ras_count_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`define BP_FE_RAS_CKPT_WIDTH(vw, dp) ((vw) + 2*$clog2(dp) + 1)

`define BP_FE_RAS_DECLARE_CKPT_S(vw, dp) \
  typedef struct packed { \
    logic [$clog2(dp)-1:0] tos_ptr; \
    logic [$clog2(dp):0]   count; \
    logic [(vw)-1:0]       top_addr; \
  } bp_fe_ras_ckpt_s

// File: rtl/bp_fe_ras_mem.sv
// Storage array for the return-address stack: one write port, one async read port.
// Latency: a write at edge N is readable after edge N; reads are combinational.
// Backpressure: none; a write is accepted every cycle.
//
// Ports:
//   i_clk, i_rst             clock, asynchronous active-high reset (clears all entries)
//   i_w_v, i_w_addr, i_w_data write strobe, index and data
//   i_r_addr, o_r_data       read index and data
module bp_fe_ras_mem
  import bp_fe_ras_pkg::*;
#(
  parameter int unsigned depth_p  = bp_fe_ras_depth_gp,
  parameter int unsigned width_p  = bp_fe_ras_vaddr_width_gp,
  localparam int unsigned addr_width_lp = bp_fe_ras_ptr_width(depth_p)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_w_v,
  input  logic [addr_width_lp-1:0] i_w_addr,
  input  logic [width_p-1:0]       i_w_data,
  input  logic [addr_width_lp-1:0] i_r_addr,
  output logic [width_p-1:0]       o_r_data
);

  logic [width_p-1:0] r_mem [depth_p];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < int'(depth_p); i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_w_v) begin
      r_mem[i_w_addr] <= i_w_data;
    end
  end

  assign o_r_data = r_mem[i_r_addr];

endmodule

// File: rtl/bp_fe_return_stack.sv
// Circular return-address stack: push on call, pop on return, predicted target on top_addr_o.
// Latency: push/pop/restore at edge N is visible on outputs after edge N; outputs come only from flops.
// Backpressure: none; push, pop, replace or restore is accepted every cycle.
//
// Ports:
//   clk_i, reset_i           clock, asynchronous active-high reset
//   push_v_i, return_addr_i  call seen: push return_addr_i
//   pop_v_i                  return seen: pop the top entry
//   top_addr_o, top_v_o      top entry (0 when empty), stack non-empty
//   count_o                  occupancy, 0..depth_p
//   ckpt_o                   {tos_ptr, count, top_addr} snapshot      (BP_FE_RAS_CHECKPOINT_EN)
//   restore_v_i, restore_i   reload pointer/count and repair the top entry (BP_FE_RAS_CHECKPOINT_EN)
//
// Optional feature macro: BP_FE_RAS_CHECKPOINT_EN adds the checkpoint/restore path.
module bp_fe_return_stack
  import bp_fe_ras_pkg::*;
#(
  parameter int unsigned vaddr_width_p = bp_fe_ras_vaddr_width_gp,
  parameter int unsigned depth_p       = bp_fe_ras_depth_gp,
  localparam int unsigned ptr_width_lp = bp_fe_ras_ptr_width(depth_p)
`ifdef BP_FE_RAS_CHECKPOINT_EN
  ,
  localparam int unsigned ckpt_width_lp = `BP_FE_RAS_CKPT_WIDTH(vaddr_width_p, depth_p)
`endif
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_v_i,
  input  logic                     pop_v_i,
  input  logic [vaddr_width_p-1:0] return_addr_i,
  output logic [vaddr_width_p-1:0] top_addr_o,
  output logic                     top_v_o,
  output logic [ptr_width_lp:0]    count_o
`ifdef BP_FE_RAS_CHECKPOINT_EN
  ,
  output logic [ckpt_width_lp-1:0] ckpt_o,
  input  logic                     restore_v_i,
  input  logic [ckpt_width_lp-1:0] restore_i
`endif
);

  localparam int unsigned cnt_width_lp = ptr_width_lp + 1;

  localparam logic [ptr_width_lp-1:0] ptr_one_lp   = ptr_width_lp'(1);
  localparam logic [ptr_width_lp-1:0] ptr_reset_lp = ptr_width_lp'(depth_p - 1);
  localparam logic [cnt_width_lp-1:0] cnt_one_lp   = cnt_width_lp'(1);
  localparam logic [cnt_width_lp-1:0] cnt_full_lp  = cnt_width_lp'(depth_p);

  logic [ptr_width_lp-1:0]  r_tos_ptr;
  logic [cnt_width_lp-1:0]  r_count;

  logic [ptr_width_lp-1:0]  w_tos_ptr_n;
  logic [cnt_width_lp-1:0]  w_count_n;
  logic                     w_mem_w_v;
  logic [ptr_width_lp-1:0]  w_mem_w_addr;
  logic [vaddr_width_p-1:0] w_mem_w_data;
  logic [vaddr_width_p-1:0] w_mem_r_data;
  logic                     w_empty;
  logic                     w_full;

`ifdef BP_FE_RAS_CHECKPOINT_EN
  `BP_FE_RAS_DECLARE_CKPT_S(vaddr_width_p, depth_p);
  bp_fe_ras_ckpt_s w_restore;
  bp_fe_ras_ckpt_s w_ckpt;

  assign w_restore = bp_fe_ras_ckpt_s'(restore_i);
`endif

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == cnt_full_lp);

  // Next-state and write-port control. Restore wins over push/pop. Push+pop
  // on a non-empty stack overwrites the top in place. On an empty stack it
  // degrades to a plain push.
  always_comb begin
    w_tos_ptr_n  = r_tos_ptr;
    w_count_n    = r_count;
    w_mem_w_v    = 1'b0;
    w_mem_w_addr = r_tos_ptr;
    w_mem_w_data = return_addr_i;

`ifdef BP_FE_RAS_CHECKPOINT_EN
    if (restore_v_i) begin
      // Rewriting the saved top undoes any wrong-path push that wrapped onto it.
      w_tos_ptr_n  = w_restore.tos_ptr;
      w_count_n    = w_restore.count;
      w_mem_w_v    = 1'b1;
      w_mem_w_addr = w_restore.tos_ptr;
      w_mem_w_data = w_restore.top_addr;
    end else
`endif
    if (push_v_i && pop_v_i && !w_empty) begin
      w_mem_w_v    = 1'b1;
      w_mem_w_addr = r_tos_ptr;
    end else if (push_v_i) begin
      // On full, the advance lands on the oldest entry and overwrites it.
      w_tos_ptr_n  = r_tos_ptr + ptr_one_lp;
      w_count_n    = w_full ? r_count : (r_count + cnt_one_lp);
      w_mem_w_v    = 1'b1;
      w_mem_w_addr = r_tos_ptr + ptr_one_lp;
    end else if (pop_v_i && !w_empty) begin
      // Contents are left in place; only the pointer retreats.
      w_tos_ptr_n  = r_tos_ptr - ptr_one_lp;
      w_count_n    = r_count - cnt_one_lp;
    end
  end

  // The pointer resets to the last slot so that the first push lands in entry 0.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_tos_ptr <= ptr_reset_lp;
      r_count   <= '0;
    end else begin
      r_tos_ptr <= w_tos_ptr_n;
      r_count   <= w_count_n;
    end
  end

  bp_fe_ras_mem #(
    .depth_p (depth_p),
    .width_p (vaddr_width_p)
  ) u_mem (
    .i_clk    (clk_i),
    .i_rst    (reset_i),
    .i_w_v    (w_mem_w_v),
    .i_w_addr (w_mem_w_addr),
    .i_w_data (w_mem_w_data),
    .i_r_addr (r_tos_ptr),
    .o_r_data (w_mem_r_data)
  );

  assign top_v_o    = !w_empty;
  assign top_addr_o = top_v_o ? w_mem_r_data : '0;
  assign count_o    = r_count;

`ifdef BP_FE_RAS_CHECKPOINT_EN
  // The snapshot is forced to zero while empty. With count 0 the pointer and
  // top carry no information, and this keeps ckpt_o at 0 out of reset.
  always_comb begin
    w_ckpt.tos_ptr  = r_tos_ptr;
    w_ckpt.count    = r_count;
    w_ckpt.top_addr = w_mem_r_data;
  end

  assign ckpt_o = top_v_o ? w_ckpt : '0;
`endif

endmodule
